cpu_bus_target: RTL and testbench

Generalised CPU external-bus slave in the FPGA fabric.
- Double-synchronises the CPU bus pins and serves read data from an external ROM array on configurable chip selects.
- Provides a byte-lane-writable register bank with readback.
- Queues console writes in a FIFO and drains them to a UART transmitter as ASCII hex words.
- Sits between the SB_IO databus buffers, the dump ROM and the UART.

---
 rtl/cpu_bus_target.sv | 231 +++++++++++++++++++++++
 tb/tb_cpu_bus_target.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_target.sv
// rtl/cpu_bus_target.sv - CPU bus slave: synchronised ROM reads, byte-lane register bank, hex console drain to UART
// Optional macro HEX_SEP_EN: follow every printed console word with one space.

module cpu_bus_target #(
  parameter int         ADDR_W      = 26,
  parameter int         ROM_AW      = 13,
  parameter logic [7:0] ROM_CS_MASK = 8'b00000001,
  parameter int         REG_CS      = 2,
  parameter int         NREG        = 4,
  parameter int         FIFO_DEPTH  = 8,
  parameter int         HEX_DIGITS  = 4
) (
  input  logic                 clk_48mhz,
  input  logic                 internal_rst,
  input  logic [ADDR_W-1:0]    a,
  input  logic [7:0]           cpu_ncs,
  input  logic                 cpu_nrd,
  input  logic                 cpu_nwrl,
  input  logic                 cpu_nwrh,
  input  logic [15:0]          databus_i,
  output logic [15:0]          databus_o,
  output logic                 databus_oe,
  output logic [ROM_AW-1:0]    rom_addr,
  input  logic [15:0]          rom_data,
  output logic [16*NREG-1:0]   reg_out,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_busy,
  output logic                 fifo_overflow
);

  localparam int         PW      = $clog2(FIFO_DEPTH);
  localparam int         CW      = PW + 1;
  localparam logic [4:0] W_STAT  = 5'(NREG);
  localparam logic [1:0] NIB_MSB = 2'(HEX_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DIGIT = 2'd2
`ifdef HEX_SEP_EN
    , S_SEP = 2'd3
`endif
  } state_t;

  logic [ADDR_W-1:0] a_s1, a_s2;
  logic [7:0]        ncs_s1, ncs_s2;
  logic              nrd_s1, nrd_s2;
  logic              nwrl_s1, nwrl_s2, nwrl_s3;
  logic              nwrh_s1, nwrh_s2, nwrh_s3;
  logic [15:0]       db_s1, db_s2;

  // Strobes reset high so no write edge appears as reset releases.
  always_ff @(posedge clk_48mhz) begin
    if (internal_rst) begin
      a_s1    <= '0;
      a_s2    <= '0;
      ncs_s1  <= 8'hFF;
      ncs_s2  <= 8'hFF;
      nrd_s1  <= 1'b1;
      nrd_s2  <= 1'b1;
      nwrl_s1 <= 1'b1;
      nwrl_s2 <= 1'b1;
      nwrl_s3 <= 1'b1;
      nwrh_s1 <= 1'b1;
      nwrh_s2 <= 1'b1;
      nwrh_s3 <= 1'b1;
      db_s1   <= '0;
      db_s2   <= '0;
    end else begin
      a_s1    <= a;
      a_s2    <= a_s1;
      ncs_s1  <= cpu_ncs;
      ncs_s2  <= ncs_s1;
      nrd_s1  <= cpu_nrd;
      nrd_s2  <= nrd_s1;
      nwrl_s1 <= cpu_nwrl;
      nwrl_s2 <= nwrl_s1;
      nwrl_s3 <= nwrl_s2;
      nwrh_s1 <= cpu_nwrh;
      nwrh_s2 <= nwrh_s1;
      nwrh_s3 <= nwrh_s2;
      db_s1   <= databus_i;
      db_s2   <= db_s1;
    end
  end

  logic       sel_rom, sel_reg, wl_edge, wh_edge;
  logic [4:0] w;
  logic       unused_addr_bits;

  assign sel_rom    = |(~ncs_s2 & ROM_CS_MASK);
  assign sel_reg    = ~ncs_s2[REG_CS];
  assign w          = a_s2[5:1];
  assign rom_addr   = a_s2[ROM_AW:1];
  assign wl_edge    = nwrl_s2 & ~nwrl_s3;
  assign wh_edge    = nwrh_s2 & ~nwrh_s3;
  assign databus_oe = (sel_rom | sel_reg) & ~nrd_s2;
  assign unused_addr_bits = &{1'b0, a_s2[ADDR_W-1:ROM_AW+1], a_s2[0]};

  logic [15:0]   regs [NREG];
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          push_req, push, pop, full;
  logic [15:0]   status, reg_rd;

  for (genvar g = 0; g < NREG; g++) begin : g_reg_out
    assign reg_out[16*g +: 16] = regs[g];
  end

  assign status = {fifo_overflow, 7'b0, 8'(fifo_count)};

  always_comb begin
    reg_rd = 16'h0000;
    for (int i = 0; i < NREG; i++) begin
      if (w == 5'(i)) reg_rd = regs[i];
    end
    if (w == W_STAT) reg_rd = status;
  end

  assign databus_o = sel_reg ? reg_rd : rom_data;

  always_ff @(posedge clk_48mhz) begin
    if (internal_rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (sel_reg) begin
      for (int i = 0; i < NREG; i++) begin
        if (w == 5'(i)) begin
          if (wl_edge) regs[i][7:0]  <= db_s2[7:0];
          if (wh_edge) regs[i][15:8] <= db_s2[15:8];
        end
      end
    end
  end

  // Either strobe edge on the console offset is one push of the whole word.
  assign push_req = sel_reg & (wl_edge | wh_edge) & (w == W_STAT);
  assign full     = (fifo_count == CW'(FIFO_DEPTH));
  assign push     = push_req & ~full;

  always_ff @(posedge clk_48mhz) begin
    if (push) fifo_mem[wr_ptr] <= db_s2;
  end

  always_ff @(posedge clk_48mhz) begin
    if (internal_rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      if (push)            wr_ptr        <= wr_ptr + PW'(1);
      if (pop)             rd_ptr        <= rd_ptr + PW'(1);
      if (push_req & full) fifo_overflow <= 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  state_t      state, state_d;
  logic [15:0] word, word_d;
  logic [1:0]  nib, nib_d;
  logic        tx_accept, tx_valid_d;
  logic [7:0]  tx_data_d;

  assign tx_accept = tx_valid & ~tx_busy;

  always_ff @(posedge clk_48mhz) begin
    if (internal_rst) begin
      state    <= S_IDLE;
      word     <= '0;
      nib      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_d;
      word     <= word_d;
      nib      <= nib_d;
      tx_valid <= tx_valid_d;
      tx_data  <= tx_data_d;
    end
  end

  // Outputs are computed from next-state so tx_valid/tx_data leave as flops.
  always_comb begin
    state_d = state;
    word_d  = word;
    nib_d   = nib;
    pop     = 1'b0;
    case (state)
      S_IDLE: if (fifo_count != '0) state_d = S_LOAD;
      S_LOAD: begin
        pop     = 1'b1;
        word_d  = fifo_mem[rd_ptr];
        nib_d   = NIB_MSB;
        state_d = S_DIGIT;
      end
      S_DIGIT: begin
        if (tx_accept) begin
          if (nib == 2'd0) begin
`ifdef HEX_SEP_EN
            state_d = S_SEP;
`else
            state_d = S_IDLE;
`endif
          end else begin
            nib_d = nib - 2'd1;
          end
        end
      end
`ifdef HEX_SEP_EN
      S_SEP: if (tx_accept) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase

    tx_valid_d = (state_d == S_DIGIT);
    tx_data_d  = hex_ascii(4'(word_d >> {nib_d, 2'b00}));
`ifdef HEX_SEP_EN
    if (state_d == S_SEP) begin
      tx_valid_d = 1'b1;
      tx_data_d  = 8'h20;
    end
`endif
  end

endmodule

// File: tb/tb_cpu_bus_target.sv
// tb/tb_cpu_bus_target.sv - randomized and directed bench for cpu_bus_target against a byte-stream/register model
// Honours HEX_SEP_EN the same way as the design.

module tb_cpu_bus_target;

  localparam int ADDR_W = 26, ROM_AW = 13, REG_CS = 2, NREG = 4, FIFO_DEPTH = 8, HEX_DIGITS = 4;
`ifdef HEX_SEP_EN
  localparam int BPW = HEX_DIGITS + 1;
`else
  localparam int BPW = HEX_DIGITS;
`endif
  localparam logic [7:0] NCS_REG = ~(8'd1 << REG_CS);

  logic                 clk_48mhz = 1'b0;
  logic                 internal_rst;
  logic [ADDR_W-1:0]    a;
  logic [7:0]           cpu_ncs;
  logic                 cpu_nrd, cpu_nwrl, cpu_nwrh;
  logic [15:0]          databus_i, databus_o;
  logic                 databus_oe;
  logic [ROM_AW-1:0]    rom_addr;
  logic [15:0]          rom_data;
  logic [16*NREG-1:0]   reg_out;
  logic [7:0]           tx_data;
  logic                 tx_valid, tx_busy, fifo_overflow;

  always #10 clk_48mhz = ~clk_48mhz;

  cpu_bus_target dut (
    .clk_48mhz(clk_48mhz), .internal_rst(internal_rst), .a(a), .cpu_ncs(cpu_ncs),
    .cpu_nrd(cpu_nrd), .cpu_nwrl(cpu_nwrl), .cpu_nwrh(cpu_nwrh), .databus_i(databus_i),
    .databus_o(databus_o), .databus_oe(databus_oe), .rom_addr(rom_addr), .rom_data(rom_data),
    .reg_out(reg_out), .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .fifo_overflow(fifo_overflow)
  );

  function automatic logic [15:0] rom_fn(input logic [ROM_AW-1:0] ad);
    return (ad == 13'd3) ? 16'hBEEF : ((16'(ad) * 16'h9E37) ^ 16'h5A5A);
  endfunction

  assign rom_data = rom_fn(rom_addr);

  int vectors = 0, miscompares = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  tx_log[$];
  logic [15:0] mregs[NREG];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model_regs();
    logic [63:0] v = '0;
    for (int i = 0; i < NREG; i++) v[16*i +: 16] = mregs[i];
    return v;
  endfunction

  // The console model: each printed word becomes its hex digits, MSB first.
  task automatic append_word(input logic [15:0] wd);
    for (int d = HEX_DIGITS - 1; d >= 0; d--) begin
      int n = int'((wd >> (4 * d)) & 16'hF);
      exp_q.push_back(n < 10 ? 8'(8'h30 + n) : 8'(8'h41 + n - 10));
    end
`ifdef HEX_SEP_EN
    exp_q.push_back(8'h20);
`endif
  endtask

  task automatic bus_write(input int cs, input int w, input logic [15:0] d,
                           input bit lo, input bit hi, input bit prints);
    @(posedge clk_48mhz); #1;
    a = ADDR_W'($urandom);
    a[5:0] = {5'(w), 1'b0};
    cpu_ncs = ~(8'd1 << cs);
    databus_i = d;
    cpu_nwrl = ~lo;
    cpu_nwrh = ~hi;
    repeat (3) @(posedge clk_48mhz);
    #1;
    if (prints) append_word(d);
    cpu_nwrl = 1'b1;
    cpu_nwrh = 1'b1;
    repeat (4) @(posedge clk_48mhz);
    #1;
    cpu_ncs = 8'hFF;
  endtask

  task automatic bus_read(input logic [7:0] ncs_v, input logic [ADDR_W-1:0] ad, input bit exp_oe,
                          input logic [15:0] exp_d, input bit chk_d, input string nm);
    @(posedge clk_48mhz); #1;
    a = ad;
    cpu_ncs = ncs_v;
    cpu_nrd = 1'b0;
    repeat (3) @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    chk({nm, "_oe"}, databus_oe, exp_oe);
    if (chk_d) chk({nm, "_data"}, databus_o, exp_d);
    @(posedge clk_48mhz); #1;
    cpu_nrd = 1'b1;
    cpu_ncs = 8'hFF;
    repeat (2) @(posedge clk_48mhz);
  endtask

  task automatic wait_tx_valid(input string nm);
    int n = 0;
    while (tx_valid !== 1'b1 && n < 200) begin
      @(negedge clk_48mhz);
      n++;
    end
    chk(nm, tx_valid, 1'b1);
  endtask

  task automatic wait_drain(input int bound, input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || tx_valid === 1'b1) && n < bound) begin
      @(negedge clk_48mhz);
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic chk_log(input string nm, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] lit[5];
    logic [7:0] got;
    lit = '{b0, b1, b2, b3, 8'h20};
    chk({nm, "_len"}, tx_log.size(), BPW);
    for (int i = 0; i < BPW; i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      chk({nm, "_byte"}, got, lit[i]);
    end
  endtask

  // Compare process: every accepted byte against the model stream, every busy cycle for stability.
  bit         prev_hold = 1'b0, prev_rst = 1'b1;
  logic [7:0] prev_data = '0;
  always @(negedge clk_48mhz) begin
    if (prev_hold && !prev_rst && !internal_rst) begin
      chk("tx_hold_valid", tx_valid, 1'b1);
      chk("tx_hold_data", tx_data, prev_data);
    end
    if (!internal_rst && tx_valid === 1'b1 && tx_busy === 1'b0) begin
      tx_log.push_back(tx_data);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL tx_unexpected: got byte %0h, required no byte", tx_data);
      end else begin
        chk("tx_byte", tx_data, exp_q.pop_front());
      end
    end
    prev_hold = (tx_valid === 1'b1) && (tx_busy === 1'b1);
    prev_data = tx_data;
    prev_rst  = internal_rst;
  end

  initial begin : main
    int r, w, k, cs;
    logic [1:0]        lanes;
    logic [15:0]       d, e;
    logic [7:0]        ncs_v, cap;
    logic [ADDR_W-1:0] ad;

    internal_rst = 1'b1;
    a = '0; cpu_ncs = 8'hFF; cpu_nrd = 1'b1; cpu_nwrl = 1'b1; cpu_nwrh = 1'b1;
    databus_i = '0; tx_busy = 1'b0;
    for (int i = 0; i < NREG; i++) mregs[i] = '0;
    repeat (3) @(posedge clk_48mhz);
    #1 internal_rst = 1'b0;
    @(negedge clk_48mhz);
    chk("rst_oe", databus_oe, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_reg_out", reg_out, 64'h0);
    chk("rst_overflow", fifo_overflow, 1'b0);

    // ROM read: output appears exactly two clocks after the pins, and leaves two after.
    @(posedge clk_48mhz); #1;
    a = 26'h6; cpu_ncs = 8'hFE; cpu_nrd = 1'b0;
    @(negedge clk_48mhz); @(negedge clk_48mhz);
    chk("rom_oe_1cyc", databus_oe, 1'b0);
    @(negedge clk_48mhz);
    chk("rom_oe_2cyc", databus_oe, 1'b1);
    chk("rom_data_beef", databus_o, 16'hBEEF);
    @(posedge clk_48mhz); #1 cpu_nrd = 1'b1;
    @(negedge clk_48mhz); @(negedge clk_48mhz);
    chk("rom_oe_hold", databus_oe, 1'b1);
    @(negedge clk_48mhz);
    chk("rom_oe_off", databus_oe, 1'b0);
    cpu_ncs = 8'hFF;

    // Byte-lane writes.
    bus_write(REG_CS, 1, 16'h12AB, 1, 0, 0);
    mregs[1] = 16'h00AB;
    chk("lane_lo", reg_out[31:16], 16'h00AB);
    bus_write(REG_CS, 1, 16'h34CD, 0, 1, 0);
    mregs[1] = 16'h34AB;
    chk("lane_hi", reg_out[31:16], 16'h34AB);
    bus_read(NCS_REG, 26'h2, 1, 16'h34AB, 1, "readback_1");

    // Console word printed as '0','A','5','F'.
    tx_log.delete();
    bus_write(REG_CS, NREG, 16'h0A5F, 1, 1, 1);
    wait_drain(300, "drain_0a5f");
    chk_log("print_0a5f", 8'h30, 8'h41, 8'h35, 8'h46);

    // Busy held across a digit.
    tx_log.delete();
    @(posedge clk_48mhz); #1 tx_busy = 1'b1;
    bus_write(REG_CS, NREG, 16'h1C3E, 0, 1, 1);
    wait_tx_valid("hold_start");
    cap = tx_data;
    chk("hold_first", cap, 8'h31);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_48mhz);
      chk("hold_valid", tx_valid, 1'b1);
      chk("hold_data", tx_data, 8'h31);
    end
    @(posedge clk_48mhz); #1 tx_busy = 1'b0;
    wait_drain(300, "drain_hold");
    chk_log("print_1c3e", 8'h31, 8'h43, 8'h33, 8'h45);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      @(posedge clk_48mhz); #1;
      tx_busy = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        k = $urandom_range(0, 3);
        cs = (k == 0) ? 0 : (k == 1) ? 1 : REG_CS;
        w = $urandom_range(0, NREG + 2);
        if (w == NREG && exp_q.size() > (FIFO_DEPTH - 3) * BPW) w = NREG + 1;
        lanes = 2'($urandom_range(1, 3));
        d = 16'($urandom);
        bus_write(cs, w, d, lanes[0], lanes[1], (cs == REG_CS && w == NREG));
        if (cs == REG_CS && w < NREG) begin
          if (lanes[0]) mregs[w][7:0]  = d[7:0];
          if (lanes[1]) mregs[w][15:8] = d[15:8];
        end
        chk("rand_reg_out", reg_out, model_regs());
      end else if (r <= 6) begin
        w = $urandom_range(0, 31);
        if (w == NREG) w = 0;
        e = (w < NREG) ? mregs[w] : 16'h0000;
        ncs_v = NCS_REG;
        if ($urandom_range(0, 1) == 1) ncs_v[0] = 1'b0;
        ad = ADDR_W'($urandom);
        ad[5:0] = {5'(w), 1'b0};
        bus_read(ncs_v, ad, 1, e, 1, "rand_reg_rd");
      end else if (r <= 8) begin
        ad = ADDR_W'($urandom);
        bus_read(8'hFE, ad, 1, rom_fn(ad[ROM_AW:1]), 1, "rand_rom_rd");
      end else begin
        ad = ADDR_W'($urandom);
        bus_read(8'hFD, ad, 0, 16'h0, 0, "rand_nosel_rd");
      end
    end
    @(posedge clk_48mhz); #1 tx_busy = 1'b0;
    wait_drain(3000, "rand_drain");

    // Overflow: the drain holds word 0 while busy, so words 1..8 fill the FIFO and word 9 drops.
    @(posedge clk_48mhz); #1 tx_busy = 1'b1;
    bus_write(REG_CS, NREG, 16'h0000, 1, 0, 1);
    wait_tx_valid("ovf_first");
    for (int i = 1; i <= 9; i++) bus_write(REG_CS, NREG, 16'(16'h1111 * i), 1, 1, (i <= 8));
    bus_read(NCS_REG, 26'(2 * NREG), 1, 16'h8008, 1, "ovf_status");
    chk("ovf_flag", fifo_overflow, 1'b1);
    @(posedge clk_48mhz); #1 tx_busy = 1'b0;
    wait_drain(3000, "ovf_drain");
    repeat (20) @(posedge clk_48mhz);
    bus_read(NCS_REG, 26'(2 * NREG), 1, 16'h8000, 1, "ovf_sticky");

    // Reset in the middle of a word.
    @(posedge clk_48mhz); #1 tx_busy = 1'b1;
    bus_write(REG_CS, NREG, 16'hFACE, 1, 1, 1);
    wait_tx_valid("rst_mid_start");
    @(posedge clk_48mhz); #1 internal_rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NREG; i++) mregs[i] = '0;
    @(posedge clk_48mhz); #1 internal_rst = 1'b0;
    @(negedge clk_48mhz);
    chk("rst_mid_valid", tx_valid, 1'b0);
    chk("rst_mid_overflow", fifo_overflow, 1'b0);
    chk("rst_mid_regs", reg_out, model_regs());
    @(posedge clk_48mhz); #1 tx_busy = 1'b0;
    bus_read(NCS_REG, 26'(2 * NREG), 1, 16'h0000, 1, "rst_mid_status");
    tx_log.delete();
    bus_write(REG_CS, NREG, 16'h7E21, 1, 1, 1);
    wait_drain(300, "drain_7e21");
    chk_log("print_7e21", 8'h37, 8'h45, 8'h32, 8'h31);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
